// File: rtl/mem_bus_master.sv
// Single-word load/store initiator for the generic memory bus.
// Each address/data/strobe set is held for HOLD_CYCLES clk cycles so a slow-clocked memory samples it safely.
module mem_bus_master #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [0:ADDR_W-1] req_addr,
    input  logic [0:DATA_W-1] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_is_read,
    output logic [0:DATA_W-1] rsp_rdata,
    output logic [0:ADDR_W-1] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [0:DATA_W-1] mem_wdata,
    input  logic [0:DATA_W-1] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              write_q, write_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_is_read_q, rsp_is_read_d;
    logic [0:DATA_W-1] rsp_rdata_q, rsp_rdata_d;
    logic [0:ADDR_W-1] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic              mem_re_q, mem_re_d;
    logic [0:DATA_W-1] mem_wdata_q, mem_wdata_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        write_d       = write_q;
        req_ready_d   = req_ready_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_is_read_d = rsp_is_read_q;
        rsp_rdata_d   = rsp_rdata_q;
        mem_addr_d    = mem_addr_q;
        mem_we_d      = mem_we_q;
        mem_re_d      = mem_re_q;
        mem_wdata_d   = mem_wdata_q;

        case (state_q)
            IDLE: begin
                // req_ready_q gates acceptance, so the first cycle after reset only raises ready
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = ACCESS;
                    req_ready_d = 1'b0;
                    write_d     = req_we;
                    mem_addr_d  = req_addr;
                    mem_wdata_d = req_wdata;
                    mem_we_d    = req_we;
                    mem_re_d    = !req_we;
                    cnt_d       = HOLD_LAST;
                end
            end
            ACCESS: begin
                if (cnt_q == 8'd0) begin
                    mem_we_d      = 1'b0;
                    mem_re_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_is_read_d = !write_q;
                    if (!write_q) begin
                        rsp_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            write_q       <= 1'b0;
            req_ready_q   <= 1'b0;
            rsp_valid_q   <= 1'b0;
            rsp_is_read_q <= 1'b0;
            rsp_rdata_q   <= '0;
            mem_addr_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_re_q      <= 1'b0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            write_q       <= write_d;
            req_ready_q   <= req_ready_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_is_read_q <= rsp_is_read_d;
            rsp_rdata_q   <= rsp_rdata_d;
            mem_addr_q    <= mem_addr_d;
            mem_we_q      <= mem_we_d;
            mem_re_q      <= mem_re_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_is_read = rsp_is_read_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_addr    = mem_addr_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign mem_wdata   = mem_wdata_q;

endmodule
